window_motor_sequencer: RTL and testbench

WINDOW_MOTOR_SEQUENCER -- requirements
Module: window_motor_sequencer

---
 rtl/window_motor_sequencer.sv | 173 +++++++++++++++++
 tb/tb_window_motor_sequencer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/window_motor_sequencer.sv
// Serialises per-window close requests onto one motor at a time, with run timeout,
// sticky per-window faults and an enforced idle gap. Define WINDOW_SEQ_ROUND_ROBIN_EN for round-robin arbitration.
module window_motor_sequencer #(
  parameter int RUN_TIMEOUT = 1000,
  parameter int GAP_CYCLES  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] motor_signal,
  input  logic [7:0] window_closed,
  input  logic       fault_clr,
  output logic [7:0] motor_en,
  output logic       busy,
  output logic       done,
  output logic [7:0] fault
);

  localparam int CNT_W = $clog2(RUN_TIMEOUT + 1);
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(RUN_TIMEOUT - 1);
  localparam logic [GAP_W-1:0] GAP_LAST     = GAP_W'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t           state_r, state_s;
  logic [2:0]       sel_r, sel_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [GAP_W-1:0] gap_r, gap_s;
  logic [7:0]       pending_r, pending_s;
  logic [7:0]       fault_r, fault_s;
  logic [7:0]       motor_en_r, motor_en_s;
  logic             busy_r, busy_s;
  logic             done_r, done_s;
  logic [7:0]       clr_mask_s;
  logic [7:0]       set_fault_s;
  logic [2:0]       start_s;
  logic [3:0]       pick_s;
`ifdef WINDOW_SEQ_ROUND_ROBIN_EN
  logic [2:0]       ptr_r, ptr_s;
`endif

  function automatic logic [7:0] onehot8(input logic [2:0] idx);
    return 8'h01 << idx;
  endfunction

  // Returns {found, index} of the first set request scanning upward from start, wrapping at 8.
  function automatic logic [3:0] pick_first(input logic [7:0] req, input logic [2:0] start);
    logic [3:0] res;
    logic [2:0] idx;
    res = 4'h0;
    for (int k = 7; k >= 0; k--) begin
      idx = start + 3'(k);
      if (req[idx]) begin
        res = {1'b1, idx};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // Next-state, arbitration, request bookkeeping and output decode.
  always_comb begin
    state_s     = state_r;
    sel_s       = sel_r;
    cnt_s       = cnt_r;
    gap_s       = gap_r;
    motor_en_s  = motor_en_r;
    done_s      = 1'b0;
    clr_mask_s  = 8'h00;
    set_fault_s = 8'h00;
`ifdef WINDOW_SEQ_ROUND_ROBIN_EN
    ptr_s   = ptr_r;
    start_s = ptr_r;
`else
    start_s = 3'd0;
`endif
    pick_s = pick_first(pending_r, start_s);

    case (state_r)
      IDLE: begin
        motor_en_s = 8'h00;
        if (pick_s[3]) begin
          sel_s      = pick_s[2:0];
          cnt_s      = CNT_W'(0);
          motor_en_s = onehot8(pick_s[2:0]);
          state_s    = RUN;
`ifdef WINDOW_SEQ_ROUND_ROBIN_EN
          ptr_s      = pick_s[2:0] + 3'd1;
`endif
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        motor_en_s = onehot8(sel_r);
        // Limit switch is checked before the timeout so a close on the last cycle is a success.
        if (window_closed[sel_r]) begin
          clr_mask_s = onehot8(sel_r);
          done_s     = 1'b1;
          motor_en_s = 8'h00;
          gap_s      = GAP_W'(0);
          state_s    = GAP;
        end else if (cnt_r == TIMEOUT_LAST) begin
          clr_mask_s  = onehot8(sel_r);
          set_fault_s = onehot8(sel_r);
          motor_en_s  = 8'h00;
          gap_s       = GAP_W'(0);
          state_s     = GAP;
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      GAP: begin
        motor_en_s = 8'h00;
        if (gap_r == GAP_LAST) begin
          state_s = IDLE;
        end else begin
          gap_s = gap_r + GAP_W'(1);
        end
      end
      default: begin
        motor_en_s = 8'h00;
        state_s    = IDLE;
      end
    endcase

    pending_s = (pending_r | motor_signal) & ~window_closed & ~fault_r & ~clr_mask_s;
    fault_s   = (fault_clr ? 8'h00 : fault_r) | set_fault_s;
    busy_s    = (state_s != IDLE);
  end

  // State and output registers; reset stops the motor immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      sel_r      <= 3'd0;
      cnt_r      <= CNT_W'(0);
      gap_r      <= GAP_W'(0);
      pending_r  <= 8'h00;
      fault_r    <= 8'h00;
      motor_en_r <= 8'h00;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
`ifdef WINDOW_SEQ_ROUND_ROBIN_EN
      ptr_r      <= 3'd0;
`endif
    end else begin
      state_r    <= state_s;
      sel_r      <= sel_s;
      cnt_r      <= cnt_s;
      gap_r      <= gap_s;
      pending_r  <= pending_s;
      fault_r    <= fault_s;
      motor_en_r <= motor_en_s;
      busy_r     <= busy_s;
      done_r     <= done_s;
`ifdef WINDOW_SEQ_ROUND_ROBIN_EN
      ptr_r      <= ptr_s;
`endif
    end
  end

  assign motor_en = motor_en_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign fault    = fault_r;

endmodule

// File: tb/tb_window_motor_sequencer.sv
// Directed bench for window_motor_sequencer: expected runs are queued as stimulus is
// applied and compared against runs observed on motor_en/done/fault.
module tb_window_motor_sequencer;

  localparam int RUN_TIMEOUT = 16;
  localparam int GAP_CYCLES  = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] motor_signal;
  logic [7:0] window_closed;
  logic       fault_clr;
  logic [7:0] motor_en;
  logic       busy;
  logic       done;
  logic [7:0] fault;

  typedef struct {
    int win;
    int len;
    int dn;
    int flt;
  } run_t;

  run_t exp_q[$];
  run_t obs_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   done_seen = 0;
  int   done_exp = 0;
  logic [2:0] mptr = 3'd0;
  logic [7:0] prev_en = 8'h00;
  int   run_len = 0;

  window_motor_sequencer #(.RUN_TIMEOUT(RUN_TIMEOUT), .GAP_CYCLES(GAP_CYCLES)) dut (
    .clk(clk), .rst_n(rst_n), .motor_signal(motor_signal), .window_closed(window_closed),
    .fault_clr(fault_clr), .motor_en(motor_en), .busy(busy), .done(done), .fault(fault)
  );

  always #5 clk = ~clk;

  function automatic int enc(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Reference arbiter: which pending window should be served next.
  function automatic int model_pick(input logic [7:0] p, input logic [2:0] start);
`ifdef WINDOW_SEQ_ROUND_ROBIN_EN
    for (int k = 0; k < 8; k++) if (p[(int'(start) + k) % 8]) return (int'(start) + k) % 8;
`else
    for (int k = 0; k < 8; k++) if (p[k]) return k;
`endif
    return -1;
  endfunction

  // Record each completed run when motor_en falls.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_en <= 8'h00;
      run_len <= 0;
    end else begin
      done_seen <= done_seen + (done ? 1 : 0);
      if (motor_en != 8'h00) begin
        run_len <= (prev_en == 8'h00) ? 1 : run_len + 1;
      end else if (prev_en != 8'h00) begin
        obs_q.push_back('{win: enc(prev_en), len: run_len, dn: int'(done),
                          flt: int'((fault & prev_en) != 8'h00)});
      end
      prev_en <= motor_en;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
    chk("onehot0", 32'($onehot0(motor_en)), 32'd1);
  endtask

  task automatic expect_run(input int win, input int len, input int dn, input int flt);
    exp_q.push_back('{win: win, len: len, dn: dn, flt: flt});
    mptr = 3'(win + 1);
    done_exp += dn;
  endtask

  task automatic wait_start(output logic [7:0] en);
    int t = 0;
    while (motor_en == 8'h00 && t < 60) begin
      tick();
      t++;
    end
    chk("run_start", 32'(motor_en != 8'h00), 32'd1);
    en = motor_en;
  endtask

  task automatic wait_obs();
    int t = 0;
    while (obs_q.size() == 0 && t < 60) begin
      tick();
      t++;
    end
  endtask

  task automatic compare_run();
    run_t e, o;
    chk("run_end_seen", 32'(obs_q.size()), 32'd1);
    if (obs_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      chk("run_win", o.win, e.win);
      chk("run_len", o.len, e.len);
      chk("run_done", o.dn, e.dn);
      chk("run_fault", o.flt, e.flt);
    end
  endtask

  // Wait for the next run, close its window so the motor ran exactly hold cycles.
  task automatic run_close(input int hold);
    logic [7:0] en;
    wait_start(en);
    repeat (hold - 1) tick();
    window_closed = en;
    wait_obs();
    window_closed = 8'h00;
    compare_run();
  endtask

  initial begin
    int first, second, g;
    logic [7:0] en;
    rst_n = 1'b0; motor_signal = 8'h00; window_closed = 8'h00; fault_clr = 1'b0;
    repeat (3) tick();
    chk("rst_motor_en", motor_en, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_fault", fault, 8'h00);
    rst_n = 1'b1;
    repeat (2) tick();

    // Single request, limit switch after 5 motor cycles.
    motor_signal = 8'h01;
    expect_run(0, 5, 1, 0);
    tick();
    chk("latency_k", motor_en, 8'h00);
    motor_signal = 8'h00;
    tick();
    chk("latency_k1", motor_en, 8'h01);
    run_close(5);
    repeat (3) tick();
    chk("gap_busy", busy, 1'b1);
    tick();
    chk("gap_end_busy", busy, 1'b0);

    // Held request that never closes: timeout, fault, then ignored until cleared.
    motor_signal = 8'h04;
    expect_run(2, RUN_TIMEOUT, 0, 1);
    wait_obs();
    compare_run();
    chk("timeout_fault", fault, 8'h04);
    chk("timeout_no_done", done_seen, done_exp);
    repeat (12) tick();
    chk("faulted_idle_en", motor_en, 8'h00);
    chk("faulted_idle_busy", busy, 1'b0);
    motor_signal = 8'h00;
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    chk("fault_clr", fault, 8'h00);
    motor_signal = 8'h04;
    tick();
    motor_signal = 8'h00;
    expect_run(2, 1, 1, 0);
    run_close(1);

    // Two simultaneous requests, served one at a time with a gap.
    motor_signal = 8'h81;
    tick();
    motor_signal = 8'h00;
    first = model_pick(8'h81, mptr);
    expect_run(first, 3, 1, 0);
    second = model_pick(8'h81 & ~(8'h01 << first), mptr);
    expect_run(second, 3, 1, 0);
    run_close(3);
    g = 1;
    while (motor_en == 8'h00 && g < 40) begin
      tick();
      if (motor_en == 8'h00) g++;
    end
    chk("gap_min", 32'(g >= GAP_CYCLES), 32'd1);
    run_close(3);

    // Arbitration after serving window 3: requests on 0 and 4.
    motor_signal = 8'h08;
    tick();
    motor_signal = 8'h00;
    expect_run(3, 2, 1, 0);
    run_close(2);
    motor_signal = 8'h11;
    tick();
    motor_signal = 8'h00;
    first = model_pick(8'h11, mptr);
    expect_run(first, 2, 1, 0);
    second = model_pick(8'h11 & ~(8'h01 << first), mptr);
    expect_run(second, 2, 1, 0);
    run_close(2);
    run_close(2);

    // Reset in the middle of a run on window 5.
    motor_signal = 8'h20;
    tick();
    motor_signal = 8'h00;
    wait_start(en);
    chk("rst_run_win", en, 8'h20);
    repeat (3) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_en", motor_en, 8'h00);
    chk("async_rst_busy", busy, 1'b0);
    chk("async_rst_fault", fault, 8'h00);
    repeat (2) tick();
    rst_n = 1'b1;
    obs_q.delete();
    mptr = 3'd0;
    repeat (6) tick();
    chk("post_rst_en", motor_en, 8'h00);
    chk("post_rst_busy", busy, 1'b0);

    // Requests for already-closed windows never start a run.
    motor_signal = 8'hFF;
    window_closed = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("closed_busy", busy, 1'b0);
    end
    motor_signal = 8'h00;
    window_closed = 8'h00;
    repeat (4) tick();
    chk("closed_after_busy", busy, 1'b0);
    chk("closed_after_en", motor_en, 8'h00);

    chk("done_count", done_seen, done_exp);
    chk("exp_left", 32'(exp_q.size()), 32'd0);
    chk("obs_left", 32'(obs_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
